phase_timer: RTL
================

// Module: phase_timer
// PURPOSE
//  Downstream timing stage for the cable clamp sequencer. Consumes its en_line_timer /
//  en_gear_timer enables and returns the line_end / gear_end completion pulses.
//  Two programmable-duration, prescaled down-counters share one tick generator.
//  Also reports remaining time, busy and an enable-conflict fault.
// PARAMETERS
//  PRESCALE  1000  clk cycles per timer tick (>=1)
//  CNT_W     16    width of duration inputs and of the remaining-time counter
// PORTS
//  clk            in   1      system clock, rising edge
//  reset          in   1      synchronous, active-high reset
//  en_line_timer  in   1      level; run line phase while high
//  en_gear_timer  in   1      level; run gear phase while high
//  line_len       in   CNT_W  line phase duration in ticks; latched at start
//  gear_len       in   CNT_W  gear phase duration in ticks; latched at start
//  line_end       out  1      1-cycle pulse: line phase elapsed
//  gear_end       out  1      1-cycle pulse: gear phase elapsed
//  busy           out  1      high in LINE_RUN or GEAR_RUN
//  remaining      out  CNT_W  ticks left in the active phase; 0 otherwise
//  fault          out  1      high in FAULT state
// BEHAVIOUR
//  Reset: one clock, synchronous, active-high. Reset values:
//   - state=IDLE; line_end=gear_end=busy=fault=0; remaining=0
//   - prescaler=0; latched lengths=0
//   - Reset mid-run aborts silently: no end pulse.
//  States: IDLE, LINE_RUN, GEAR_RUN, DONE, FAULT.
//  IDLE:
//   - both enables high -> FAULT
//   - en_line_timer only -> LINE_RUN; latch line_len into remaining; prescaler=0
//   - en_gear_timer only -> GEAR_RUN; latch gear_len into remaining; prescaler=0
//  *_RUN:
//   - Prescaler counts 0..PRESCALE-1. Tick when it wraps at PRESCALE-1.
//   - Each tick decrements remaining.
//   - Tick with remaining==1 -> pulse the matching *_end, remaining=0, go to DONE.
//   - Latched length 0 -> pulse *_end on the first cycle in RUN, then DONE.
//   - Own enable drops -> IDLE: abort, remaining=0, no pulse, prescaler cleared.
//   - Other enable rises while running -> FAULT: abort, no pulse.
//  DONE:
//   - Hold until both enables are low, then IDLE.
//   - Prevents re-trigger while the sequencer still holds the enable.
//  FAULT:
//   - Sticky until both enables are low, then IDLE.
//   - Outputs a single-cycle clear path only (no counting).
//  Latency:
//   - Enable first sampled high at edge E, length N>=1: *_end is high for exactly
//     the one cycle following edge E+N*PRESCALE.
//   - N=0: *_end high in the cycle following edge E+1.
//  Outputs:
//   - All outputs registered. line_end and gear_end are never high together.
//   - busy and remaining reflect the state/count after each edge.
//  Arithmetic and boundaries:
//   - Duration inputs are unsigned. Max length is 2^CNT_W-1 with no wrap.
//   - Length inputs are ignored except at the IDLE->RUN transition.
//   - Tick and enable drop on the same edge: abort wins, no pulse.
// TESTING
//  1 PRESCALE=4, line_len=3, en_line_timer held high from edge 0:
//    line_end=1 only in cycle after edge 12; remaining steps 3,2,1,0; DONE until enable low.
//  2 PRESCALE=4, gear_len=0, en_gear_timer high:
//    gear_end pulses after edge 1; busy high for 1 cycle; no second pulse while enable stays high.
//  3 PRESCALE=4, line_len=5, drop en_line_timer after edge 9:
//    no line_end; remaining=0; IDLE; a re-raise restarts the full count from 5.
//  4 Both enables raised on the same edge, or gear raised during LINE_RUN:
//    fault=1, no end pulses; drop both -> fault=0 and IDLE next edge.
//  5 reset=1 asserted mid GEAR_RUN (remaining=7):
//    next edge all outputs 0, IDLE; no gear_end even after reset is released.
//  6 Back-to-back: line phase completes, line enable drops, gear enable rises the next cycle:
//    gear_len is latched correctly; gear_end timing follows the latency rule.

Source files
------------

// File: rtl/phase_timer_if.sv
// Enable/length/completion bundle between the clamp sequencer and its phase timer.
interface phase_timer_if #(
   parameter int CNT_W = 16
);
   logic             en_line_timer;
   logic             en_gear_timer;
   logic [CNT_W-1:0] line_len;
   logic [CNT_W-1:0] gear_len;
   logic             line_end;
   logic             gear_end;
   logic             busy;
   logic [CNT_W-1:0] remaining;
   logic             fault;

   modport master (
      output en_line_timer, en_gear_timer, line_len, gear_len,
      input  line_end, gear_end, busy, remaining, fault
   );

   modport slave (
      input  en_line_timer, en_gear_timer, line_len, gear_len,
      output line_end, gear_end, busy, remaining, fault
   );
endinterface

// File: rtl/phase_timer.sv
// Line/gear phase timer: two prescaled down-counters sharing one tick
// generator, with end pulses, busy, remaining time and enable-conflict fault.
module phase_timer #(
   parameter int PRESCALE = 1000,
   parameter int CNT_W    = 16
) (
   input logic          clk,
   input logic          reset,
   phase_timer_if.slave tif
);
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

   typedef enum logic [2:0] {
      IDLE, LINE_RUN, GEAR_RUN, DONE, FAULT
   } state_t;

   state_t           state, state_n;
   logic [PW-1:0]    pre, pre_n;
   logic [CNT_W-1:0] rem, rem_n;
   logic             line_end_n, gear_end_n;
   logic             line_end_q, gear_end_q;
   logic             busy_q, fault_q;
   logic             own, other, tick;

   assign own   = (state == LINE_RUN) ? tif.en_line_timer
                                      : tif.en_gear_timer;
   assign other = (state == LINE_RUN) ? tif.en_gear_timer
                                      : tif.en_line_timer;
   assign tick  = (pre == PRE_LAST);

   always_comb begin
      state_n    = state;
      pre_n      = pre;
      rem_n      = rem;
      line_end_n = 1'b0;
      gear_end_n = 1'b0;
      unique case (state)
         IDLE: begin
            if (tif.en_line_timer && tif.en_gear_timer) begin
               state_n = FAULT;
            end else if (tif.en_line_timer) begin
               state_n = LINE_RUN;
               rem_n   = tif.line_len;
               pre_n   = '0;
            end else if (tif.en_gear_timer) begin
               state_n = GEAR_RUN;
               rem_n   = tif.gear_len;
               pre_n   = '0;
            end
         end
         LINE_RUN, GEAR_RUN: begin
            // abort beats a coincident tick; rem==0 here only for a zero length
            if (!own || other) begin
               state_n = own ? FAULT : IDLE;
               rem_n   = '0;
               pre_n   = '0;
            end else if (rem == '0 || (tick && rem == CNT_W'(1))) begin
               state_n    = DONE;
               rem_n      = '0;
               pre_n      = '0;
               line_end_n = (state == LINE_RUN);
               gear_end_n = (state == GEAR_RUN);
            end else if (tick) begin
               pre_n = '0;
               rem_n = rem - CNT_W'(1);
            end else begin
               pre_n = pre + PW'(1);
            end
         end
         DONE, FAULT: begin
            if (!tif.en_line_timer && !tif.en_gear_timer)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         pre        <= '0;
         rem        <= '0;
         line_end_q <= 1'b0;
         gear_end_q <= 1'b0;
         busy_q     <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state      <= state_n;
         pre        <= pre_n;
         rem        <= rem_n;
         line_end_q <= line_end_n;
         gear_end_q <= gear_end_n;
         busy_q     <= (state_n == LINE_RUN) || (state_n == GEAR_RUN);
         fault_q    <= (state_n == FAULT);
      end
   end

   assign tif.line_end  = line_end_q;
   assign tif.gear_end  = gear_end_q;
   assign tif.busy      = busy_q;
   assign tif.remaining = rem;
   assign tif.fault     = fault_q;
endmodule
